// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
package hex_disp_pkg;

    localparam int NUM_DIGITS = 4;

    // All segments dark (active low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Digit currently being scanned; digit 0 is the rightmost.
    typedef enum logic [1:0] {
        DIG0,
        DIG1,
        DIG2,
        DIG3
    } digit_e;

endpackage

// File: rtl/hex_digit_scanner_if.sv
// PIO-side data and display-pin bundle for hex_digit_scanner.
// master = the CPU/PIO side driving the data, slave = the scanner.
interface hex_digit_scanner_if
    import hex_disp_pkg::*;
;
    logic [15:0]            hex_in;
    logic [NUM_DIGITS-1:0]  dp_in;
    logic                   blank_lz;
    logic [2:0]             brightness;
    logic                   enable;
    logic [6:0]             seg_n;
    logic                   dp_n;
    logic [NUM_DIGITS-1:0]  an_n;
    logic                   frame_start;

    modport master (
        output hex_in, dp_in, blank_lz, brightness, enable,
        input  seg_n, dp_n, an_n, frame_start
    );

    modport slave (
        input  hex_in, dp_in, blank_lz, brightness, enable,
        output seg_n, dp_n, an_n, frame_start
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Table lookup of the segment pattern for one nibble
    always_comb begin
        seg_n = SEG_LUT[nibble];
    end

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame
// input snapshot, leading-zero blanking, decimal points and PWM dimming.
module hex_digit_scanner
    import hex_disp_pkg::*;
#(
    parameter int DIGIT_TICKS = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    hex_digit_scanner_if.slave  bus
);

    localparam int SUB_TICKS = DIGIT_TICKS / 8;

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       sub_cnt;
    logic [2:0]             sub;
    digit_e                 idx;
    logic [15:0]            hex_sh;
    logic [NUM_DIGITS-1:0]  dp_sh;

    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   blanked;
    logic [6:0]             cur_seg;
    logic                   snap;
    logic                   cnt_last;
    logic                   sub_last;
    logic                   lit;

    // Select the shadowed nibble/dp of the scanned digit and its blanking state
    always_comb begin
        cur_nib = hex_sh[3:0];
        cur_dp  = dp_sh[0];
        blanked = 1'b0;
        case (idx)
            DIG0: begin
                cur_nib = hex_sh[3:0];
                cur_dp  = dp_sh[0];
                blanked = 1'b0;
            end
            DIG1: begin
                cur_nib = hex_sh[7:4];
                cur_dp  = dp_sh[1];
                blanked = bus.blank_lz && (hex_sh[15:4] == '0);
            end
            DIG2: begin
                cur_nib = hex_sh[11:8];
                cur_dp  = dp_sh[2];
                blanked = bus.blank_lz && (hex_sh[15:8] == '0);
            end
            DIG3: begin
                cur_nib = hex_sh[15:12];
                cur_dp  = dp_sh[3];
                blanked = bus.blank_lz && (hex_sh[15:12] == '0);
            end
        endcase
    end

    // Slot timing decodes and anode gating; cnt = 0 is the dark guard cycle
    always_comb begin
        snap     = (cnt == '0) && (idx == DIG0);
        cnt_last = (cnt == CNT_W'(DIGIT_TICKS - 1));
        sub_last = (sub_cnt == CNT_W'(SUB_TICKS - 1));
        lit      = bus.enable && (cnt != '0) && (sub <= bus.brightness) && !blanked;
    end

    hex_to_seg7 u_dec (
        .nibble (cur_nib),
        .seg_n  (cur_seg)
    );

    // Prescaler, digit scan, frame snapshot and registered display outputs.
    // sub (= cnt / SUB_TICKS) is tracked by its own sub-slot counter instead
    // of a divider; both restart together with cnt so they never drift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt             <= '0;
            sub_cnt         <= '0;
            sub             <= '0;
            idx             <= DIG0;
            hex_sh          <= '0;
            dp_sh           <= '0;
            bus.frame_start <= 1'b0;
            bus.an_n        <= '1;
            bus.seg_n       <= SEG_OFF;
            bus.dp_n        <= 1'b1;
        end else begin
            if (!bus.enable) begin
                cnt     <= '0;
                sub_cnt <= '0;
                sub     <= '0;
                idx     <= DIG0;
            end else if (cnt_last) begin
                cnt     <= '0;
                sub_cnt <= '0;
                sub     <= '0;
                case (idx)
                    DIG0: idx <= DIG1;
                    DIG1: idx <= DIG2;
                    DIG2: idx <= DIG3;
                    DIG3: idx <= DIG0;
                endcase
            end else begin
                cnt <= cnt + 1'b1;
                if (sub_last) begin
                    sub_cnt <= '0;
                    sub     <= sub + 1'b1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            bus.frame_start <= bus.enable && snap;
            if (bus.enable && snap) begin
                hex_sh <= bus.hex_in;
                dp_sh  <= bus.dp_in;
            end

            if (lit) begin
                bus.an_n  <= ~(NUM_DIGITS'(1) << idx);
                bus.seg_n <= cur_seg;
                bus.dp_n  <= ~cur_dp;
            end else begin
                bus.an_n  <= '1;
                bus.seg_n <= SEG_OFF;
                bus.dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed-vector bench for hex_digit_scanner with a 16-cycle digit slot.
// Output sample k (taken at the falling edge after the k-th rising edge
// following reset release) shows slot position (k-1) of the frame.
module tb_hex_digit_scanner;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    hex_digit_scanner_if dif ();

    hex_digit_scanner #(
        .DIGIT_TICKS (16),
        .CNT_W       (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic        blz;
        logic [2:0]  br;
        int          dig;
        int          pos;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpn;
    } vec_t;

    vec_t vecs [23];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic set_in(input logic [15:0] hex, input logic [3:0] dp,
                          input logic blz, input logic [2:0] br);
        dif.hex_in     = hex;
        dif.dp_in      = dp;
        dif.blank_lz   = blz;
        dif.brightness = br;
        dif.enable     = 1'b1;
    endtask

    initial begin
        logic [3:0] e_an;

        vecs[0]  = '{16'h12AF, 4'h0, 1'b0, 3'd7, 0,  1, 4'hE, 7'h0E, 1'b1};
        vecs[1]  = '{16'h12AF, 4'h0, 1'b0, 3'd7, 1,  5, 4'hD, 7'h08, 1'b1};
        vecs[2]  = '{16'h12AF, 4'h0, 1'b0, 3'd7, 2, 15, 4'hB, 7'h24, 1'b1};
        vecs[3]  = '{16'h12AF, 4'h0, 1'b0, 3'd7, 3,  8, 4'h7, 7'h79, 1'b1};
        vecs[4]  = '{16'h12AF, 4'h0, 1'b0, 3'd7, 1,  0, 4'hF, 7'h7F, 1'b1};
        vecs[5]  = '{16'h0040, 4'h0, 1'b1, 3'd7, 3,  4, 4'hF, 7'h7F, 1'b1};
        vecs[6]  = '{16'h0040, 4'h0, 1'b1, 3'd7, 2,  4, 4'hF, 7'h7F, 1'b1};
        vecs[7]  = '{16'h0040, 4'h0, 1'b1, 3'd7, 1,  4, 4'hD, 7'h19, 1'b1};
        vecs[8]  = '{16'h0040, 4'h0, 1'b1, 3'd7, 0,  4, 4'hE, 7'h40, 1'b1};
        vecs[9]  = '{16'h0000, 4'h0, 1'b1, 3'd7, 0,  3, 4'hE, 7'h40, 1'b1};
        vecs[10] = '{16'h0000, 4'h0, 1'b1, 3'd7, 1,  3, 4'hF, 7'h7F, 1'b1};
        vecs[11] = '{16'h0000, 4'h0, 1'b0, 3'd7, 3,  3, 4'h7, 7'h40, 1'b1};
        vecs[12] = '{16'h12AF, 4'h0, 1'b0, 3'd0, 0,  1, 4'hE, 7'h0E, 1'b1};
        vecs[13] = '{16'h12AF, 4'h0, 1'b0, 3'd0, 0,  2, 4'hF, 7'h7F, 1'b1};
        vecs[14] = '{16'h12AF, 4'h0, 1'b0, 3'd3, 0,  7, 4'hE, 7'h0E, 1'b1};
        vecs[15] = '{16'h12AF, 4'h0, 1'b0, 3'd3, 0,  8, 4'hF, 7'h7F, 1'b1};
        vecs[16] = '{16'h12AF, 4'h0, 1'b0, 3'd7, 0, 15, 4'hE, 7'h0E, 1'b1};
        vecs[17] = '{16'h12AF, 4'h4, 1'b0, 3'd7, 2,  3, 4'hB, 7'h24, 1'b0};
        vecs[18] = '{16'h12AF, 4'h4, 1'b0, 3'd7, 1,  3, 4'hD, 7'h08, 1'b1};
        vecs[19] = '{16'h12AF, 4'h4, 1'b0, 3'd0, 2,  3, 4'hF, 7'h7F, 1'b1};
        vecs[20] = '{16'h0040, 4'h8, 1'b1, 3'd7, 3,  3, 4'hF, 7'h7F, 1'b1};
        vecs[21] = '{16'h0300, 4'h0, 1'b1, 3'd7, 2,  9, 4'hB, 7'h30, 1'b1};
        vecs[22] = '{16'h0300, 4'h0, 1'b1, 3'd7, 1,  9, 4'hD, 7'h40, 1'b1};

        // Reset values while reset is held
        set_in(16'h12AF, 4'h0, 1'b0, 3'd7);
        @(negedge clk);
        @(negedge clk);
        check("rst an_n", 32'(dif.an_n), 32'hF);
        check("rst seg_n", 32'(dif.seg_n), 32'h7F);
        check("rst dp_n", 32'(dif.dp_n), 32'h1);
        check("rst frame_start", 32'(dif.frame_start), 32'h0);

        // Release: frame_start at cycle 1, one anode per slot except guard cycles
        reset_n = 1'b1;
        cyc = 0;
        adv_to(1);
        check("fs first", 32'(dif.frame_start), 32'h1);
        check("guard first", 32'(dif.an_n), 32'hF);
        adv_to(2);
        check("fs drop", 32'(dif.frame_start), 32'h0);
        for (int p = 1; p < 64; p++) begin
            adv_to(p + 1);
            e_an = 4'hF;
            if (p % 16 != 0) e_an = ~(4'(1) << (p / 16));
            check($sformatf("scan an_n p%0d", p), 32'(dif.an_n), 32'(e_an));
        end
        adv_to(65);
        check("fs second frame", 32'(dif.frame_start), 32'h1);

        // Table-driven single-point checks
        for (int i = 0; i < 23; i++) begin
            set_in(vecs[i].hex, vecs[i].dp, vecs[i].blz, vecs[i].br);
            do_reset();
            adv_to(vecs[i].dig * 16 + vecs[i].pos + 1);
            check($sformatf("vec%0d an_n", i), 32'(dif.an_n), 32'(vecs[i].an));
            check($sformatf("vec%0d seg_n", i), 32'(dif.seg_n), 32'(vecs[i].seg));
            check($sformatf("vec%0d dp_n", i), 32'(dif.dp_n), 32'(vecs[i].dpn));
        end

        // Tear-free update: new value mid-frame appears only next frame
        set_in(16'h1234, 4'h0, 1'b0, 3'd7);
        do_reset();
        adv_to(22);
        check("tear d1 old", 32'(dif.seg_n), 32'h30);
        dif.hex_in = 16'h5678;
        adv_to(38);
        check("tear d2 old", 32'(dif.seg_n), 32'h24);
        adv_to(54);
        check("tear d3 old", 32'(dif.seg_n), 32'h79);
        adv_to(65);
        check("tear fs", 32'(dif.frame_start), 32'h1);
        adv_to(70);
        check("tear d0 new", 32'(dif.seg_n), 32'h00);
        adv_to(86);
        check("tear d1 new", 32'(dif.seg_n), 32'h78);
        adv_to(118);
        check("tear d3 new", 32'(dif.seg_n), 32'h12);

        // Enable drop mid-frame and restart
        set_in(16'h12AF, 4'h4, 1'b0, 3'd7);
        do_reset();
        adv_to(38);
        check("en d2 an_n", 32'(dif.an_n), 32'hB);
        check("en d2 dp_n", 32'(dif.dp_n), 32'h0);
        dif.enable = 1'b0;
        dif.hex_in = 16'h0040;
        adv_to(39);
        check("dis an_n", 32'(dif.an_n), 32'hF);
        check("dis seg_n", 32'(dif.seg_n), 32'h7F);
        check("dis dp_n", 32'(dif.dp_n), 32'h1);
        check("dis fs", 32'(dif.frame_start), 32'h0);
        adv_to(42);
        check("dis hold an_n", 32'(dif.an_n), 32'hF);
        dif.enable = 1'b1;
        adv_to(43);
        check("reen fs", 32'(dif.frame_start), 32'h1);
        check("reen guard", 32'(dif.an_n), 32'hF);
        adv_to(44);
        check("reen d0 an_n", 32'(dif.an_n), 32'hE);
        check("reen d0 seg_n", 32'(dif.seg_n), 32'h40);
        adv_to(60);
        check("reen d1 an_n", 32'(dif.an_n), 32'hD);
        check("reen d1 seg_n", 32'(dif.seg_n), 32'h19);

        // Asynchronous reset mid-slot darkens outputs without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check("async an_n", 32'(dif.an_n), 32'hF);
        check("async seg_n", 32'(dif.seg_n), 32'h7F);
        check("async dp_n", 32'(dif.dp_n), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_digit_scanner.md
Name: hex_digit_scanner

Overview:
Consumes the 16-bit hex_digits PIO out_port and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Scans one digit per slot.
- Snapshots input data once per frame, so a CPU write mid-scan never produces a torn display.
- Provides leading-zero blanking, per-digit decimal points and 8-level PWM brightness.
- Sits between the Avalon PIO and the board display pins.

Parameters:
- DIGIT_TICKS, 50000: clk cycles per digit slot (1 ms at 50 MHz); must be a multiple of 8 and >= 16.
- CNT_W, 16: prescaler counter width; must satisfy 2**CNT_W >= DIGIT_TICKS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hex_in  in  16  four hex nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal point request per digit, active high.
- blank_lz  in  1  1 = blank leading zero digits.
- brightness  in  3  0 = dimmest (1/8 of slot), 7 = full slot.
- enable  in  1  0 = display dark and scanner held.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- an_n  out  4  digit anodes, active low, one-hot-or-none.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active low.
- Reset values:
  - an_n = 4'hF, seg_n = 7'h7F, dp_n = 1, frame_start = 0.
  - Prescaler cnt = 0, digit index idx = 0.
  - Shadow registers: hex_sh = 0, dp_sh = 0.
- Prescaler:
  - cnt counts 0..DIGIT_TICKS-1 while enable = 1.
  - At terminal count, cnt wraps to 0 and idx advances 0->1->2->3->0.
- Snapshot:
  - Taken on the cycle cnt = 0 and idx = 0, including the first enabled cycle after reset or after enable rises.
  - On that cycle: hex_sh <= hex_in, dp_sh <= dp_in, and frame_start is asserted on the next cycle.
  - Input changes at any other time are ignored until the next frame.
- Anode gating (combinational):
  - sub = cnt / (DIGIT_TICKS/8), range 0..7.
  - Digit idx is lit iff enable = 1, cnt != 0, sub <= brightness, and the digit is not blanked.
  - The cnt = 0 cycle is a mandatory dark guard cycle that prevents ghosting between digits.
- Leading-zero blanking:
  - With blank_lz = 1, digit i (i = 1..3) is blanked iff hex_sh nibbles i..3 are all zero.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - A blanked digit keeps an_n[i] = 1 for the whole slot, including its decimal point.
- Segment decode (active low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78.
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- Output latency: seg_n, dp_n and an_n are registered, one cycle behind the internal cnt/idx state. When a digit is dark, seg_n = 7'h7F and dp_n = 1.
- enable = 0:
  - cnt and idx are forced to 0; all outputs go inactive on the next cycle.
  - Shadow registers are held.
  - On re-enable, a snapshot is taken immediately.
- brightness and blank_lz are sampled live every cycle; they are not snapshotted.
- Reset asserted mid-frame: all registers return to their reset values asynchronously; outputs go dark immediately.

Decomposition:
- Package hex_disp_pkg: NUM_DIGITS = 4, the SEG_LUT constant array (16 x 7 bit, values above), and SEG_OFF = 7'h7F.
- Sub-module hex_to_seg7: combinational nibble-to-seg_n decoder that indexes SEG_LUT.
- Prescaler, scan FSM, snapshot and gating logic all live in the top module.

Test Plan:
- Reset with enable = 1: release reset; expect frame_start at cycle 1, then in each digit slot exactly one an_n bit low except on guard cycles. Run with DIGIT_TICKS = 16.
- Basic frame: hex_in = 16'h12AF, blank_lz = 0, brightness = 7; expect digit 0 seg_n = 0E, digit 1 = 08, digit 2 = 24, digit 3 = 79, with an_n = E, D, B, 7 respectively.
- Tear-free update: change hex_in from 16'h1234 to 16'h5678 mid-slot of digit 1; the rest of that frame still shows 1234, and the next frame after frame_start shows 5678.
- Leading-zero blanking: blank_lz = 1 with hex_in = 16'h0040 -> digits 3 and 2 dark (an_n bits stay 1), digit 1 = 19, digit 0 = 40. Then hex_in = 16'h0000 -> only digit 0 lit, showing 40.
- Brightness: with DIGIT_TICKS = 16, brightness = 0 -> an_n active on slot cycles 1..1 only; brightness = 3 -> cycles 1..7; brightness = 7 -> cycles 1..15. The guard cycle is dark in all three cases.
- Enable and dp: with dp_in = 4'b0100, confirm dp_n = 0 only while digit 2 is lit. Drop enable mid-frame -> all outputs inactive next cycle. Raise enable -> frame_start pulses and the scan restarts at digit 0.
